// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply/divide sequencer owning HI/LO
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdat,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DZ} state_t;

    state_t             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_raw, rem_raw, quot_fix, rem_fix;

    // acc holds {upper, lower}: multiply uses lower as the multiplier, divide as {rem, quot}
    always_comb begin
        rs_abs   = (op[0] && rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_abs   = (op[0] && rt_val[WIDTH-1]) ? -rt_val : rt_val;
        add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
        mul_next = {add_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge       = (rem_sh >= {1'b0, b_q});
        rem_new  = ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        div_next = {rem_new, acc_q[WIDTH-2:0], ge};
        prod_fix = neg_q_q ? -acc_q : acc_q;
        quot_raw = acc_q[WIDTH-1:0];
        rem_raw  = acc_q[2*WIDTH-1:WIDTH];
        quot_fix = neg_q_q ? -quot_raw : quot_raw;
        rem_fix  = neg_r_q ? -rem_raw : rem_raw;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdat;
                if (lo_we) lo_d = wdat;
                if (start && !abort) begin
                    is_div_d = op[1];
                    neg_q_d  = op[0] & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                    neg_r_d  = op[0] & rs_val[WIDTH-1];
                    b_d      = rt_abs;
                    cnt_d    = '0;
                    if (op[1] && rt_val == '0) begin
                        // DZ reports the dividend as presented, not its magnitude
                        state_d = S_DZ;
                        acc_d   = {rs_val, {WIDTH{1'b0}}};
                    end else begin
                        state_d = S_RUN;
                        acc_d   = {{WIDTH{1'b0}}, rs_abs};
                    end
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                hi_d    = acc_q[2*WIDTH-1:WIDTH];
                lo_d    = '1;
                done_d  = 1'b1;
                dz_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dz_d    = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - randomized self-checking bench for mul_div_unit
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        abort = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdat = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_pass = 0;
    int n_total = 0;

    mul_div_unit #(.WIDTH(32), .CNTW(6)) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
        .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdat(wdat),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // MIPS-style arithmetic from plain 64-bit integer math
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        edz = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFFFFFF; edz = 1'b1;
                end else if (o == 2'b10) begin
                    el = a / b; eh = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end
            end
        endcase
    endfunction

    // launches in the current cycle; lat = cycles until done (capped at 60)
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        op = o; rs_val = a; rt_val = b; start = 1'b1;
        lat = 0; bcnt = 0;
        do begin
            tick();
            lat++;
            start = 1'b0;
            rs_val = $urandom;
            rt_val = $urandom;
            if (busy) bcnt++;
        end while (!done && lat < 60);
    endtask

    task automatic test_reset();
        #2 nRST = 1'b0;
        #2;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_total++; if (div_zero !== 1'b0) $display("FAIL reset_dz: got %b want 0", div_zero); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
        repeat (2) @(posedge CLK);
        @(negedge CLK) nRST = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        int lat, bcnt;
        issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        n_total++; if (lat !== 34) $display("FAIL multu_lat: got %0d want 34", lat); else n_pass++;
        n_total++; if (hi !== 32'hFFFFFFFE) $display("FAIL multu_hi: got %h want fffffffe", hi); else n_pass++;
        n_total++; if (lo !== 32'h00000001) $display("FAIL multu_lo: got %h want 00000001", lo); else n_pass++;
        n_total++; if (div_zero !== 1'b0) $display("FAIL multu_dz: got %b want 0", div_zero); else n_pass++;
        tick();
        issue(2'b01, 32'hFFFFFFFD, 32'd5, lat, bcnt);
        n_total++; if (bcnt !== 33) $display("FAIL mult_busy_cycles: got %0d want 33", bcnt); else n_pass++;
        n_total++; if (hi !== 32'hFFFFFFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else n_pass++;
        n_total++; if (lo !== 32'hFFFFFFF1) $display("FAIL mult_lo: got %h want fffffff1", lo); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL mult_busy_done: got %b want 0", busy); else n_pass++;
        issue(2'b11, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        n_total++; if (lo !== 32'hFFFFFFFD) $display("FAIL div_neg_lo: got %h want fffffffd", lo); else n_pass++;
        n_total++; if (hi !== 32'hFFFFFFFF) $display("FAIL div_neg_hi: got %h want ffffffff", hi); else n_pass++;
        issue(2'b10, 32'd100, 32'd7, lat, bcnt);
        n_total++; if (lo !== 32'd14) $display("FAIL divu_lo: got %0d want 14", lo); else n_pass++;
        n_total++; if (hi !== 32'd2) $display("FAIL divu_hi: got %0d want 2", hi); else n_pass++;
        issue(2'b10, 32'd5, 32'd0, lat, bcnt);
        n_total++; if (lat !== 2) $display("FAIL dz_lat: got %0d want 2", lat); else n_pass++;
        n_total++; if (div_zero !== 1'b1) $display("FAIL dz_flag: got %b want 1", div_zero); else n_pass++;
        n_total++; if (hi !== 32'd5) $display("FAIL dz_hi: got %h want 5", hi); else n_pass++;
        n_total++; if (lo !== 32'hFFFFFFFF) $display("FAIL dz_lo: got %h want ffffffff", lo); else n_pass++;
        issue(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        n_total++; if (lat !== 34) $display("FAIL ovf_lat: got %0d want 34", lat); else n_pass++;
        n_total++; if (lo !== 32'h80000000) $display("FAIL ovf_lo: got %h want 80000000", lo); else n_pass++;
        n_total++; if (hi !== 32'h0) $display("FAIL ovf_hi: got %h want 0", hi); else n_pass++;
        n_total++; if (div_zero !== 1'b0) $display("FAIL ovf_dz: got %b want 0", div_zero); else n_pass++;
    endtask

    task automatic test_random();
        int lat, bcnt, sel;
        logic [1:0] o;
        logic [31:0] a, b, eh, el;
        logic edz;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            sel = $urandom_range(0, 7);
            b = (sel == 0) ? 32'd0 : (sel == 1) ? $urandom_range(1, 9) : (sel == 2) ? 32'hFFFFFFFF : $urandom;
            ref_model(o, a, b, eh, el, edz);
            issue(o, a, b, lat, bcnt);
            n_total++; if (lat !== (edz ? 2 : 34)) $display("FAIL rand_lat op=%0d: got %0d want %0d", o, lat, edz ? 2 : 34); else n_pass++;
            n_total++; if (hi !== eh) $display("FAIL rand_hi op=%0d a=%h b=%h: got %h want %h", o, a, b, hi, eh); else n_pass++;
            n_total++; if (lo !== el) $display("FAIL rand_lo op=%0d a=%h b=%h: got %h want %h", o, a, b, lo, el); else n_pass++;
            n_total++; if (div_zero !== edz) $display("FAIL rand_dz op=%0d: got %b want %b", o, div_zero, edz); else n_pass++;
            tick();
            n_total++; if ({done, div_zero} !== 2'b00) $display("FAIL rand_pulse: got %b want 00", {done, div_zero}); else n_pass++;
        end
    endtask

    task automatic test_abort();
        int lat, bcnt, ndone;
        hi_we = 1'b1; wdat = 32'h11; tick();
        hi_we = 1'b0; lo_we = 1'b1; wdat = 32'h22; tick();
        lo_we = 1'b0;
        n_total++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL preload: got %h/%h want 11/22", hi, lo); else n_pass++;
        op = 2'b00; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        tick(); start = 1'b0;
        repeat (9) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_run_busy: got %b want 0", busy); else n_pass++;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) ndone++;
            tick();
        end
        n_total++; if (ndone !== 0) $display("FAIL abort_run_done: got %0d pulses want 0", ndone); else n_pass++;
        n_total++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL abort_run_hilo: got %h/%h want 11/22", hi, lo); else n_pass++;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_start_idle: got busy %b want 0", busy); else n_pass++;
        op = 2'b00; rs_val = 32'd7; rt_val = 32'd9; start = 1'b1;
        tick(); start = 1'b0;
        repeat (32) tick();
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL abort_fix: got busy/done %b want 00", {busy, done}); else n_pass++;
        n_total++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL abort_fix_hilo: got %h/%h want 11/22", hi, lo); else n_pass++;
        op = 2'b10; rs_val = 32'd9; rt_val = 32'd0; start = 1'b1;
        tick(); start = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        n_total++; if ({done, div_zero} !== 2'b00) $display("FAIL abort_dz: got %b want 00", {done, div_zero}); else n_pass++;
        n_total++; if (hi !== 32'h11) $display("FAIL abort_dz_hi: got %h want 11", hi); else n_pass++;
        op = 2'b00; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
        tick(); start = 1'b0;
        repeat (4) tick();
        hi_we = 1'b1; lo_we = 1'b1; wdat = 32'hDEAD; tick(); hi_we = 1'b0; lo_we = 1'b0;
        n_total++; if ({hi, lo} !== {32'h11, 32'h22}) $display("FAIL we_busy: got %h/%h want 11/22", hi, lo); else n_pass++;
        lat = 0;
        while (!done && lat < 60) begin tick(); lat++; end
        n_total++; if ({hi, lo} !== {32'h0, 32'd12}) $display("FAIL we_busy_result: got %h/%h want 0/c", hi, lo); else n_pass++;
        hi_we = 1'b1; wdat = 32'h77; op = 2'b00; rs_val = 32'd2; rt_val = 32'd5; start = 1'b1;
        tick(); start = 1'b0; hi_we = 1'b0;
        n_total++; if ({busy, hi} !== {1'b1, 32'h77}) $display("FAIL we_start: got %b/%h want 1/77", busy, hi); else n_pass++;
        lat = 0;
        while (!done && lat < 60) begin tick(); lat++; end
        n_total++; if ({hi, lo} !== {32'h0, 32'd10}) $display("FAIL we_start_result: got %h/%h want 0/a", hi, lo); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        logic [31:0] a, b, eh, el;
        logic edz;
        op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            start = (k >= 5 && k <= 20);
            op = 2'b00; rs_val = $urandom; rt_val = $urandom;
        end
        start = 1'b0;
        n_total++; if (done !== 1'b1) $display("FAIL b2b_done34: got %b want 1", done); else n_pass++;
        n_total++; if ({hi, lo} !== {32'd1, 32'd333}) $display("FAIL b2b_first: got %h/%h want 1/14d", hi, lo); else n_pass++;
        a = $urandom; b = $urandom | 32'h1;
        ref_model(2'b11, a, b, eh, el, edz);
        issue(2'b11, a, b, lat, bcnt);
        n_total++; if (lat !== 34) $display("FAIL b2b_second_lat: got %0d want 34", lat); else n_pass++;
        n_total++; if ({hi, lo} !== {eh, el}) $display("FAIL b2b_second: got %h/%h want %h/%h", hi, lo, eh, el); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        op = 2'b00; rs_val = 32'hFFFF; rt_val = 32'hFFFF; start = 1'b1;
        tick(); start = 1'b0;
        repeat (14) tick();
        #2 nRST = 1'b0;
        #1;
        n_total++; if ({busy, done} !== 2'b00) $display("FAIL rst_mid_busy_done: got %b want 00", {busy, done}); else n_pass++;
        n_total++; if ({hi, lo} !== 64'h0) $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi, lo); else n_pass++;
        @(negedge CLK) nRST = 1'b1;
        tick();
        issue(2'b00, 32'd2, 32'd3, lat, bcnt);
        n_total++; if (lat !== 34) $display("FAIL rst_after_lat: got %0d want 34", lat); else n_pass++;
        n_total++; if ({hi, lo} !== {32'd0, 32'd6}) $display("FAIL rst_after_result: got %h/%h want 0/6", hi, lo); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
